// File: rtl/booth_pkg.sv
// Shared encodings for the Booth multiplier family: FSM state codes,
// Booth recoding pairs and the step-counter width helper.
package booth_pkg;

  localparam logic [0:0] ENC_IDLE = 1'b0;
  localparam logic [0:0] ENC_RUN  = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = ENC_IDLE,
    ST_RUN  = ENC_RUN
  } state_t;

  // {Q[0], q_m1} pairs that request an add or a subtract of M
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // The counter must hold 0..width+1 without wrapping
  function automatic int count_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: recode {Q[0],q_m1}, add/sub M into A,
// then arithmetic right shift of the combined {A,Q,q_m1} register.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] a,
  input  logic [WIDTH:0]   q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH+1:0] a_next,
  output logic [WIDTH:0]   q_next,
  output logic             q_m1_next
);

  logic [1:0]       pair;
  logic [WIDTH+1:0] m_sx;
  logic [WIDTH+1:0] sum;

  assign pair = {q[0], q_m1};
  // A carries one guard bit, so M is sign-extended by one more bit
  assign m_sx = {m[WIDTH], m};

  // Recoded add/subtract of the multiplicand into the accumulator
  always_comb begin
    sum = a;
    if (pair == BOOTH_ADD) begin
      sum = a + m_sx;
    end else if (pair == BOOTH_SUB) begin
      sum = a - m_sx;
    end
  end

  // Arithmetic shift right across {A,Q,q_m1}
  assign a_next    = {sum[WIDTH+1], sum[WIDTH+1:1]};
  assign q_next    = {sum[0], q[WIDTH:1]};
  assign q_m1_next = q[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier with signed/unsigned mode and a
// start/busy/done handshake. One add/sub plus one shift per clock.
module booth_multiplier_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = count_width(WIDTH);

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [WIDTH+1:0]   a_reg, a_next;
  logic [WIDTH:0]     q_reg, q_next;
  logic [WIDTH:0]     m_reg;
  logic               qm1_reg, qm1_next;
  logic [2*WIDTH-1:0] product_reg;
  logic               done_reg;
  logic               accept, step, last;

  // Operands are widened by one bit so unsigned MSB=1 stays positive
  function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] v, input logic s);
    return s ? {v[WIDTH-1], v} : {1'b0, v};
  endfunction

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a         (a_reg),
    .q         (q_reg),
    .q_m1      (qm1_reg),
    .m         (m_reg),
    .a_next    (a_next),
    .q_next    (q_next),
    .q_m1_next (qm1_next)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and datapath control strobes
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        // WIDTH+1 steps: counts 0..WIDTH, the last one completes
        if (count_reg == CW'(WIDTH)) begin
          last       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand latch, iteration registers, result register and done pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg   <= '0;
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      qm1_reg     <= 1'b0;
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        m_reg     <= extend(multiplicand, signed_mode);
        q_reg     <= extend(multiplier, signed_mode);
        a_reg     <= '0;
        qm1_reg   <= 1'b0;
        count_reg <= '0;
      end else if (step) begin
        a_reg     <= a_next;
        q_reg     <= q_next;
        qm1_reg   <= qm1_next;
        count_reg <= count_reg + CW'(1);
        if (last) begin
          // Low 2*WIDTH bits of {A,Q}; exact for both modes
          product_reg <= {a_next[WIDTH-2:0], q_next};
          done_reg    <= 1'b1;
        end
      end
    end
  end

  assign product = product_reg;
  assign busy    = (state_reg == ST_RUN);
  assign done    = done_reg;

endmodule
